prio_arbiter_rr: RTL and testbench

- Parametrised, registered successor to the team's 4:2 priority encoder.
- Takes N request lines and selects one, either by fixed priority (highest index wins, as in the 4:2 encoder) or by rotating round-robin priority.
- Presents the winner as a registered index plus one-hot grant, using a valid/ready handshake.
- Sits between request sources (DMA channels, interrupt lines) and a single shared consumer.

---
 rtl/prio_arb_pkg.sv | 17 +
 rtl/prio_pick.sv | 31 +++
 rtl/prio_arbiter_rr.sv | 71 +++++++
 tb/tb_prio_arbiter_rr.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// Shared definitions for the round-robin / fixed-priority arbiter.
package prio_arb_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Ceiling log2, valid for 1..2^31; used to size the grant index.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: searches req downward from start, wrapping modulo N,
// and returns the first set index.
module prio_pick
   import prio_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   // Walk start, start-1, ..., 0, N-1, ..., start+1; the first hit wins.
   always_comb begin
      int pos;
      any = 1'b0;
      idx = '0;
      pos = 0;
      for (int k = 0; k < N; k++) begin
         pos = int'(start) - k;
         if (pos < 0) pos = pos + N;
         if (!any && req[pos]) begin
            any = 1'b1;
            idx = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/prio_arbiter_rr.sv
// N-way arbiter with registered grant, fixed (highest index wins) or
// round-robin priority.
//
// Handshake: gnt_valid/gnt_idx/gnt_onehot form one registered grant. A grant
// is transferred on a rising edge where gnt_valid && gnt_ready. While
// gnt_valid && !gnt_ready the grant is frozen, whatever req/en/rr_mode do.
// A new grant may be loaded in the same cycle an old one is accepted.
module prio_arbiter_rr
   import prio_arb_pkg::*;
#(
   parameter  int N     = 4,
   localparam int IDX_W = clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             rr_mode,
   input  logic [N-1:0]     req,
   output logic             gnt_valid,
   input  logic             gnt_ready,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [N-1:0]     gnt_onehot
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] start;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             load;

   // Fixed mode always searches from the top; RR searches from ptr.
   assign start = (rr_mode == MODE_RR) ? ptr : LAST_IDX;
   // pick_any is equivalent to |req.
   assign load  = en && pick_any && (!gnt_valid || gnt_ready);

   prio_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req),
      .start (start),
      .any   (pick_any),
      .idx   (pick_idx)
   );

   // Grant register and RR pointer; ptr only moves on RR-mode loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         ptr       <= LAST_IDX;
      end else if (load) begin
         gnt_valid <= 1'b1;
         gnt_idx   <= pick_idx;
         if (rr_mode == MODE_RR) begin
            ptr <= (pick_idx == '0) ? LAST_IDX : pick_idx - 1'b1;
         end
      end else if (gnt_ready) begin
         gnt_valid <= 1'b0;
      end
   end

   // One-hot view of the registered index, blanked when nothing is pending.
   always_comb begin
      gnt_onehot = '0;
      if (gnt_valid) gnt_onehot[gnt_idx] = 1'b1;
   end

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Directed bench for prio_arbiter_rr (N=4) with an expected-grant queue.
module tb_prio_arbiter_rr;

   localparam int N     = 4;
   localparam int IDX_W = 2;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             rr_mode;
   logic [N-1:0]     req;
   logic             gnt_valid;
   logic             gnt_ready;
   logic [IDX_W-1:0] gnt_idx;
   logic [N-1:0]     gnt_onehot;

   logic [IDX_W-1:0] exp_q[$];
   int checks;
   int failures;

   prio_arbiter_rr #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .rr_mode    (rr_mode),
      .req        (req),
      .gnt_valid  (gnt_valid),
      .gnt_ready  (gnt_ready),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic rr, input logic [N-1:0] r, input logic rdy);
      en        = e;
      rr_mode   = rr;
      req       = r;
      gnt_ready = rdy;
   endtask

   // Monitor: every accepted grant is compared against the head of exp_q.
   always @(negedge clk) begin
      if (rst_n && gnt_valid && gnt_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_grant", {30'd0, gnt_idx}, 32'hFFFF_FFFF);
         end else begin
            logic [IDX_W-1:0] e;
            logic [N-1:0]     e_oh;
            e = exp_q.pop_front();
            e_oh = '0;
            e_oh[e] = 1'b1;
            check("grant_idx", {30'd0, gnt_idx}, {30'd0, e});
            check("grant_onehot", {28'd0, gnt_onehot}, {28'd0, e_oh});
         end
      end
   end

   initial begin
      logic [N-1:0] fixed_req[4];
      logic [IDX_W-1:0] fixed_exp[4];
      logic [IDX_W-1:0] rr_exp[6];
      logic [IDX_W-1:0] alt_exp[4];
      checks   = 0;
      failures = 0;
      fixed_req = '{4'b0001, 4'b0011, 4'b0110, 4'b1010};
      fixed_exp = '{2'd0, 2'd1, 2'd2, 2'd3};
      rr_exp    = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
      alt_exp   = '{2'd0, 2'd2, 2'd0, 2'd2};

      // Reset state
      rst_n = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0);
      repeat (3) tick();
      check("reset_valid", {31'd0, gnt_valid}, 32'd0);
      check("reset_idx", {30'd0, gnt_idx}, 32'd0);
      check("reset_onehot", {28'd0, gnt_onehot}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Fixed priority, one request pattern per cycle, ready held high
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, fixed_req[i], 1'b1);
         exp_q.push_back(fixed_exp[i]);
         tick();
         check("fixed_latency_valid", {31'd0, gnt_valid}, 32'd1);
      end
      drive(1'b1, 1'b0, '0, 1'b1);
      tick();
      check("accept_clears_valid", {31'd0, gnt_valid}, 32'd0);
      check("accept_clears_onehot", {28'd0, gnt_onehot}, 32'd0);
      check("accept_holds_idx", {30'd0, gnt_idx}, 32'd3);

      // en=0 blocks loading
      drive(1'b0, 1'b0, 4'b1000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("en_low_no_grant", {31'd0, gnt_valid}, 32'd0);
      end
      drive(1'b1, 1'b0, 4'b1000, 1'b1);
      exp_q.push_back(2'd3);
      tick();
      check("en_high_grant_valid", {31'd0, gnt_valid}, 32'd1);
      drive(1'b1, 1'b0, '0, 1'b1);
      tick();

      // Round-robin rotation over all four requesters (ptr still 3)
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, 4'b1111, 1'b1);
         exp_q.push_back(rr_exp[i]);
         tick();
      end
      // ptr is now 1: 0101 alternates 0, 2, 0, 2
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 4'b0101, 1'b1);
         exp_q.push_back(alt_exp[i]);
         tick();
      end
      // Single request with ptr=1 still wins; ptr becomes 2, seen via 1111 -> 2
      drive(1'b1, 1'b1, 4'b1000, 1'b1);
      exp_q.push_back(2'd3);
      tick();
      drive(1'b1, 1'b1, 4'b1111, 1'b1);
      exp_q.push_back(2'd2);
      tick();
      drive(1'b1, 1'b1, '0, 1'b1);
      tick();
      check("rr_drained_valid", {31'd0, gnt_valid}, 32'd0);

      // Backpressure in fixed mode: grant frozen while req changes
      drive(1'b1, 1'b0, 4'b0100, 1'b0);
      exp_q.push_back(2'd2);
      tick();
      drive(1'b1, 1'b0, 4'b1000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", {31'd0, gnt_valid}, 32'd1);
         check("stall_idx", {30'd0, gnt_idx}, 32'd2);
         check("stall_onehot", {28'd0, gnt_onehot}, 32'h4);
      end
      exp_q.push_back(2'd3);
      drive(1'b1, 1'b0, 4'b1000, 1'b1);
      tick();
      drive(1'b1, 1'b0, 4'b1000, 1'b0);
      check("after_stall_idx", {30'd0, gnt_idx}, 32'd3);
      check("after_stall_valid", {31'd0, gnt_valid}, 32'd1);
      tick();
      drive(1'b1, 1'b0, '0, 1'b1);
      tick();

      // Async reset mid-cycle with a pending RR grant (ptr=1 -> 0100 gives 2)
      drive(1'b1, 1'b1, 4'b0100, 1'b0);
      tick();
      check("pre_reset_valid", {31'd0, gnt_valid}, 32'd1);
      check("pre_reset_idx", {30'd0, gnt_idx}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", {31'd0, gnt_valid}, 32'd0);
      check("async_reset_onehot", {28'd0, gnt_onehot}, 32'd0);
      drive(1'b0, 1'b1, '0, 1'b1);
      tick();
      tick();
      rst_n = 1'b1;
      check("post_reset_idx", {30'd0, gnt_idx}, 32'd0);
      drive(1'b1, 1'b1, 4'b1111, 1'b1);
      exp_q.push_back(2'd3);
      tick();
      drive(1'b1, 1'b1, '0, 1'b1);
      tick();

      // Drain with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("queue_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
